ddt_tx_timing_gen: RTL and testbench
====================================

# ddt_tx_timing_gen

Frame-buffer-to-DDT transmitter: free-running raster generator that reads pixels from the external SRAM and drives a DDT-format video output (active-low VSA/HSA, DE, 8-bit R/G/B). It is the transmit counterpart of the DDT capture path: the capture side writes incoming DDT frames into SRAM, and this block replays a stored frame onto a DDT port for loop-back, display or downstream test.

## Interface
Parameters:
- H_SYNC, 4: HSA_Inv low width, pixels
- H_BP, 4: horizontal back porch, pixels
- H_ACTIVE, 800: active pixels per line
- H_FP, 4: horizontal front porch, pixels
- V_SYNC, 2 / V_BP, 2 / V_ACTIVE, 480 / V_FP, 2: vertical equivalents, lines
- RD_LAT, 2: SRAM read latency, cycles from Rd_EN to valid Rd_Data (1..8)

Ports:
- Sys_Clock  in  1  single clock, also the pixel clock
- Reset  in  1  synchronous, active-high
- Enable  in  1  run request, sampled at frame boundary only
- Base_Addr  in  21  SRAM address of pixel (0,0), latched at frame start
- Rd_EN  out  1  SRAM read strobe, one per active pixel
- Rd_Addr  out  21  SRAM read address
- Rd_Data  in  27  SRAM read word; [23:16]=R, [15:8]=G, [7:0]=B, [26:24] ignored
- DDT_VSA_Inv  out  1  vertical sync, active low
- DDT_HSA_Inv  out  1  horizontal sync, active low
- DDT_DE  out  1  data enable
- DDT_R / DDT_G / DDT_B  out  8 each  pixel data, 0 when DDT_DE=0
- Frame_Start  out  1  one-cycle pulse at internal h=0,v=0 while running

## Operation
- H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL likewise. h_cnt 0..H_TOTAL-1, v_cnt 0..V_TOTAL-1; h wraps increments v; v wraps at V_TOTAL-1.
- Internal (pre-delay) signals: hs_n = !(h_cnt < H_SYNC); vs_n = !(v_cnt < V_SYNC); de = h in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) AND v in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
- States: IDLE, RUN, DRAIN. IDLE: counters 0, Rd_EN=0. IDLE->RUN when Enable=1 (counters start at 0 next cycle). RUN->DRAIN when Enable=0 at last cycle of frame (h=H_TOTAL-1, v=V_TOTAL-1); otherwise frame repeats. DRAIN: RD_LAT+1 cycles flushing delay line, then IDLE.
- Enable deassert mid-frame: current frame completes in full; no truncated frames.
- Base_Addr latched at h=0,v=0 of each frame (double buffering safe); mid-frame changes ignored.
- Rd_EN = internal de; Rd_Addr = base latch + pixel index; increments by 1 per Rd_EN, contiguous across lines (stride H_ACTIVE), modulo 2^21 wrap.
- hs_n, vs_n, de pass through an RD_LAT+1-stage shift register; output stage registers DDT_* with RGB from Rd_Data when delayed de=1, else 0.

## Timing
- Reset values: Rd_EN=0, Rd_Addr=0, DDT_VSA_Inv=1, DDT_HSA_Inv=1, DDT_DE=0, RGB=0, Frame_Start=0, state IDLE, delay line filled with idle (1,1,0).
- Latency: pixel whose Rd_EN is high at cycle t appears on DDT_* at cycle t+RD_LAT+1; syncs delayed identically, so sync/DE/data always mutually aligned.
- Frame_Start asserted in the cycle counters equal (0,0), undelayed.
- Reset mid-frame: all outputs return to reset values next cycle, no drain.
- Enable and last-cycle-of-frame coincident: Enable value in that cycle decides continue/stop.

## Configuration
- DDT_TX_TEST_PATTERN_EN defined: adds input Pattern_Sel (1 bit); when 1, RGB replaced by 8 vertical colour bars (bar = pixel column*8/H_ACTIVE, colour = {bar[2],bar[1],bar[0]} each expanded to 8'hFF/8'h00), Rd_EN held 0; timing unchanged. Pattern_Sel sampled at frame start.
- Undefined: no Pattern_Sel port; data always from SRAM.

## Structure
- Shared package ddt_pkg: 21-bit address and 27-bit word widths, RGB field offsets in the SRAM word, state enum, default timing constants.
- One sub-module: ddt_raster_cnt (h/v counters, region decode, Frame_Start); top holds FSM, address generator, delay line, output regs.

## Test plan
- Small timing (H 2/2/8/2, V 1/1/4/1, RD_LAT=2), Enable=1 -> 14-cycle lines, 7-line frames; HSA_Inv low 2 cycles, DE high 8 cycles/line for 4 lines, first DDT_DE 3 cycles after first Rd_EN.
- SRAM model returns word = address; Base_Addr=0x1000 -> Rd_Addr 0x1000..0x101F per frame, DDT_B/G tracks low address bytes, Rd_Data[26:24]=7 has no effect.
- Base_Addr=0x1FFFFC -> addresses wrap 0x1FFFFF->0x000000 without glitch.
- Enable dropped at mid-frame -> frame completes, DRAIN RD_LAT+1 cycles, outputs idle (1,1,0,0); Base_Addr change mid-frame takes effect only next frame.
- Reset asserted mid-line -> next cycle all outputs at reset values; Enable held -> new frame from (0,0) with Frame_Start pulse.
- With DDT_TX_TEST_PATTERN_EN, Pattern_Sel=1 -> Rd_EN never high, column 0 RGB=000000, last column FFFFFF.

Source files
------------

// File: rtl/ddt_pkg.sv
// Shared widths, SRAM word layout, FSM state type and default raster timing
// for the DDT transmit path.
package ddt_pkg;

  localparam int ADDR_W = 21;
  localparam int WORD_W = 27;
  localparam int R_LSB  = 16;
  localparam int G_LSB  = 8;
  localparam int B_LSB  = 0;

  localparam int DEF_H_SYNC   = 4;
  localparam int DEF_H_BP     = 4;
  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 4;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 2;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 2;
  localparam int DEF_RD_LAT   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [7:0] word_field(input logic [WORD_W-1:0] w, input int lsb);
    return w[lsb +: 8];
  endfunction

endpackage

// File: rtl/ddt_raster_cnt.sv
// Free-running h/v raster counters with sync/active-region decode.
// Counters sit at (0,0) whenever run is low.
module ddt_raster_cnt #(
  parameter int H_SYNC   = 4,
  parameter int H_BP     = 4,
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 4,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 2,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic hs_n,
  output logic vs_n,
  output logic de,
  output logic frame_start,
  output logic frame_last
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;

  assign h_last = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last = (v_cnt == VW'(V_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign hs_n = (h_cnt >= HW'(H_SYNC));
  assign vs_n = (v_cnt >= VW'(V_SYNC));
  assign de   = (h_cnt >= HW'(H_SYNC + H_BP)) && (h_cnt < HW'(H_SYNC + H_BP + H_ACTIVE)) &&
                (v_cnt >= VW'(V_SYNC + V_BP)) && (v_cnt < VW'(V_SYNC + V_BP + V_ACTIVE));

  assign frame_start = run && (h_cnt == '0) && (v_cnt == '0);
  assign frame_last  = run && h_last && v_last;

endmodule

// File: rtl/ddt_tx_timing_gen.sv
// Frame-buffer-to-DDT transmitter: raster FSM, SRAM address generator, sync delay
// line and output registers. Optional colour-bar source under DDT_TX_TEST_PATTERN_EN.
module ddt_tx_timing_gen
  import ddt_pkg::*;
#(
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int RD_LAT   = DEF_RD_LAT
) (
  input  logic              Sys_Clock,
  input  logic              Reset,
  input  logic              Enable,
  input  logic [ADDR_W-1:0] Base_Addr,
`ifdef DDT_TX_TEST_PATTERN_EN
  input  logic              Pattern_Sel,
`endif
  output logic              Rd_EN,
  output logic [ADDR_W-1:0] Rd_Addr,
  input  logic [WORD_W-1:0] Rd_Data,
  output logic              DDT_VSA_Inv,
  output logic              DDT_HSA_Inv,
  output logic              DDT_DE,
  output logic [7:0]        DDT_R,
  output logic [7:0]        DDT_G,
  output logic [7:0]        DDT_B,
  output logic              Frame_Start
);

  state_t            state;
  logic [3:0]        drain_cnt;
  logic              run;
  logic              hs_n, vs_n, de, frame_start, frame_last;
  logic              hs_p0, vs_p0, de_p0, pat_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [RD_LAT-1:0] hs_dly, vs_dly, de_dly;
  logic [7:0]        pix_r, pix_g, pix_b;
  logic              unused_hi;

  assign run = (state == ST_RUN);

  ddt_raster_cnt #(
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP)
  ) u_raster (
    .clk(Sys_Clock),
    .rst(Reset),
    .run(run),
    .hs_n(hs_n),
    .vs_n(vs_n),
    .de(de),
    .frame_start(frame_start),
    .frame_last(frame_last)
  );

  // Enable is only honoured at the frame boundary so frames are never truncated.
  always_ff @(posedge Sys_Clock) begin
    if (Reset) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE:  if (Enable) state <= ST_RUN;
        ST_RUN: begin
          if (frame_last && !Enable) begin
            state     <= ST_DRAIN;
            drain_cnt <= 4'(RD_LAT);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) state <= ST_IDLE;
          else                 drain_cnt <= drain_cnt - 1'b1;
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Stage p0: undelayed raster, idle levels outside RUN.
  assign hs_p0 = !run || hs_n;
  assign vs_p0 = !run || vs_n;
  assign de_p0 = run && de;
  assign Rd_EN = de_p0 && !pat_p0;
  assign Rd_Addr     = addr_p0;
  assign Frame_Start = frame_start;

  // Sync interlocks never reach the first active pixel, so loading the base at (0,0) is safe.
  always_ff @(posedge Sys_Clock) begin
    if (Reset)            addr_p0 <= '0;
    else if (frame_start) addr_p0 <= Base_Addr;
    else if (Rd_EN)       addr_p0 <= addr_p0 + 1'b1;
  end

  // Stages p1..pRD_LAT: align syncs/DE with the SRAM read return.
  always_ff @(posedge Sys_Clock) begin
    if (Reset) begin
      hs_dly <= '1;
      vs_dly <= '1;
      de_dly <= '0;
    end else begin
      hs_dly[0] <= hs_p0;
      vs_dly[0] <= vs_p0;
      de_dly[0] <= de_p0;
      for (int i = 1; i < RD_LAT; i++) begin
        hs_dly[i] <= hs_dly[i-1];
        vs_dly[i] <= vs_dly[i-1];
        de_dly[i] <= de_dly[i-1];
      end
    end
  end

`ifdef DDT_TX_TEST_PATTERN_EN
  localparam int AW = $clog2(H_ACTIVE + 8);

  logic              pat_q;
  logic [2:0]        bar;
  logic [AW-1:0]     bar_acc, acc_nxt;
  logic [RD_LAT-1:0] pat_dly;
  logic [2:0]        bar_dly [RD_LAT];

  assign pat_p0  = pat_q;
  assign acc_nxt = bar_acc + AW'(8);

  always_ff @(posedge Sys_Clock) begin
    if (Reset) begin
      pat_q   <= 1'b0;
      pat_dly <= '0;
    end else begin
      if (frame_start) pat_q <= Pattern_Sel;
      pat_dly[0] <= pat_p0;
      for (int i = 1; i < RD_LAT; i++) pat_dly[i] <= pat_dly[i-1];
    end
  end

  // bar = column*8/H_ACTIVE tracked incrementally: acc holds (8*column) mod H_ACTIVE.
  always_ff @(posedge Sys_Clock) begin
    if (!de_p0) begin
      bar_acc <= '0;
      bar     <= '0;
    end else if (acc_nxt >= AW'(H_ACTIVE)) begin
      bar_acc <= acc_nxt - AW'(H_ACTIVE);
      bar     <= bar + 1'b1;
    end else begin
      bar_acc <= acc_nxt;
    end
    bar_dly[0] <= bar;
    for (int i = 1; i < RD_LAT; i++) bar_dly[i] <= bar_dly[i-1];
  end
`else
  assign pat_p0 = 1'b0;
`endif

  assign unused_hi = ^Rd_Data[WORD_W-1:R_LSB+8];

  always_comb begin
    pix_r = word_field(Rd_Data, R_LSB);
    pix_g = word_field(Rd_Data, G_LSB);
    pix_b = word_field(Rd_Data, B_LSB);
`ifdef DDT_TX_TEST_PATTERN_EN
    if (pat_dly[RD_LAT-1]) begin
      pix_r = {8{bar_dly[RD_LAT-1][2]}};
      pix_g = {8{bar_dly[RD_LAT-1][1]}};
      pix_b = {8{bar_dly[RD_LAT-1][0]}};
    end
`endif
  end

  // Output stage: pixel data forced to zero outside DE.
  always_ff @(posedge Sys_Clock) begin
    if (Reset) begin
      DDT_VSA_Inv <= 1'b1;
      DDT_HSA_Inv <= 1'b1;
      DDT_DE      <= 1'b0;
      DDT_R       <= '0;
      DDT_G       <= '0;
      DDT_B       <= '0;
    end else begin
      DDT_VSA_Inv <= vs_dly[RD_LAT-1];
      DDT_HSA_Inv <= hs_dly[RD_LAT-1];
      DDT_DE      <= de_dly[RD_LAT-1];
      DDT_R       <= de_dly[RD_LAT-1] ? pix_r : 8'h00;
      DDT_G       <= de_dly[RD_LAT-1] ? pix_g : 8'h00;
      DDT_B       <= de_dly[RD_LAT-1] ? pix_b : 8'h00;
    end
  end

endmodule

// File: tb/tb_ddt_tx_timing_gen.sv
// Directed bench for ddt_tx_timing_gen on a small raster, with an SRAM model and a
// pixel scoreboard. Exercises the colour-bar source when DDT_TX_TEST_PATTERN_EN is set.
module tb_ddt_tx_timing_gen;

  localparam int HS = 2, HB = 2, HA = 8, HF = 2;
  localparam int VS = 1, VB = 1, VA = 4, VF = 1;
  localparam int LAT = 2;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [20:0] base;
  logic        rd_en;
  logic [20:0] rd_addr;
  logic [26:0] rd_data;
  logic        vsa, hsa, de;
  logic [7:0]  r, g, b;
  logic        fs;
  logic        psel;

  always #5 clk = ~clk;

  ddt_tx_timing_gen #(
    .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF), .RD_LAT(LAT)
  ) dut (
    .Sys_Clock(clk),
    .Reset(rst),
    .Enable(en),
    .Base_Addr(base),
`ifdef DDT_TX_TEST_PATTERN_EN
    .Pattern_Sel(psel),
`endif
    .Rd_EN(rd_en),
    .Rd_Addr(rd_addr),
    .Rd_Data(rd_data),
    .DDT_VSA_Inv(vsa),
    .DDT_HSA_Inv(hsa),
    .DDT_DE(de),
    .DDT_R(r),
    .DDT_G(g),
    .DDT_B(b),
    .Frame_Start(fs)
  );

  // SRAM model: word = address, with junk in the ignored top bits.
  logic [20:0] sram_pipe [LAT];
  always @(posedge clk) begin
    sram_pipe[0] <= rd_addr;
    for (int i = 1; i < LAT; i++) sram_pipe[i] <= sram_pipe[i-1];
  end
  assign rd_data = {3'b111, 3'b000, sram_pipe[LAT-1]};

  typedef enum {M_IDLE, M_RUN, M_DRAIN} mst_t;
  typedef struct { int due; logic [23:0] rgb; } px_t;

  mst_t        m_st = M_IDLE;
  int          m_pos, m_left, m_k, cyc;
  logic [20:0] m_base;
  bit          m_pat;
  logic [2:0]  hist [3];
  px_t         sb [$];
  int          tests, fails, rd_cnt, first_rd, first_de, c0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [23:0] bar_rgb(input int col);
    int         bar;
    logic [2:0] bb;
    bar = (col * 8) / HA;
    bb  = 3'(bar);
    return {{8{bb[2]}}, {8{bb[1]}}, {8{bb[0]}}};
  endfunction

  // Advance one clock, update the reference raster model and check every output.
  task automatic tick();
    logic [2:0]  cur, oexp;
    logic [20:0] a;
    px_t         p;
    int          h, v;
    bit          r0;
    r0 = rst;
    if (r0) begin
      m_st = M_IDLE; m_pos = 0; m_pat = 0;
    end else begin
      case (m_st)
        M_IDLE: if (en) begin m_st = M_RUN; m_pos = 0; end
        M_RUN: begin
          if (m_pos == FT - 1) begin
            if (en) m_pos = 0;
            else begin m_st = M_DRAIN; m_left = LAT + 1; end
          end else m_pos++;
        end
        M_DRAIN: begin m_left--; if (m_left == 0) m_st = M_IDLE; end
        default: m_st = M_IDLE;
      endcase
    end
    @(posedge clk); #1;
    cyc++;
    if (r0) begin
      for (int i = 0; i < 3; i++) hist[i] = 3'b110;
      sb.delete();
    end
    if (m_st == M_RUN && m_pos == 0) begin
      m_base = base; m_k = 0; m_pat = psel;
    end
    h = m_pos % HT;
    v = m_pos / HT;
    if (m_st == M_RUN)
      cur = {1'(h >= HS), 1'(v >= VS),
             1'(h >= HS + HB && h < HS + HB + HA && v >= VS + VB && v < VS + VB + VA)};
    else
      cur = 3'b110;
    oexp = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = cur;

    if (rd_en) rd_cnt++;
    if (rd_en && first_rd < 0) first_rd = cyc;
    if (de && first_de < 0) first_de = cyc;

    chk("rd_en", 32'(rd_en), 32'(cur[0] && !m_pat));
    chk("frame_start", 32'(fs), 32'(m_st == M_RUN && m_pos == 0));
    if (cur[0]) begin
      a = m_base + 21'(m_k);
      if (!m_pat) chk("rd_addr", 32'(rd_addr), 32'(a));
      p.due = cyc + LAT + 1;
      p.rgb = m_pat ? bar_rgb(h - HS - HB) : {3'b000, a[20:16], a[15:8], a[7:0]};
      sb.push_back(p);
      m_k++;
    end
    chk("hsa_inv", 32'(hsa), 32'(oexp[2]));
    chk("vsa_inv", 32'(vsa), 32'(oexp[1]));
    chk("ddt_de", 32'(de), 32'(oexp[0]));
    if (de) begin
      chk("sb_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        p = sb.pop_front();
        chk("px_latency", 32'(cyc), 32'(p.due));
        chk("px_rgb", 32'({r, g, b}), 32'(p.rgb));
      end
    end else begin
      chk("rgb_blank", 32'({r, g, b}), 32'd0);
    end
  endtask

  task automatic wait_fs(input int budget);
    int n;
    n = 0;
    do begin tick(); n++; end while (!fs && n < budget);
    chk("frame_start_seen", 32'(fs), 32'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vsa"}, 32'(vsa), 32'd1);
    chk({tag, "_hsa"}, 32'(hsa), 32'd1);
    chk({tag, "_de"}, 32'(de), 32'd0);
    chk({tag, "_rgb"}, 32'({r, g, b}), 32'd0);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_fs"}, 32'(fs), 32'd0);
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; rd_cnt = 0; first_rd = -1; first_de = -1;
    m_pat = 0; m_pos = 0; m_k = 0; m_base = '0;
    for (int i = 0; i < 3; i++) hist[i] = 3'b110;
    rst = 1'b1; en = 1'b0; base = 21'h001000; psel = 1'b0;

    repeat (3) tick();
    chk_idle("reset");
    chk("reset_rd_addr", 32'(rd_addr), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Frame 1: base 0x1000, timing and latency.
    en = 1'b1;
    wait_fs(4);
    c0 = cyc; rd_cnt = 0;
    repeat (FT - 1) tick();
    chk("rd_per_frame", 32'(rd_cnt), 32'd32);
    wait_fs(2);
    chk("frame_period", 32'(cyc - c0), 32'(FT));
    chk("first_de_latency", 32'(first_de - first_rd), 32'(LAT + 1));

    // Frame 2: mid-frame base change must wait for the next frame.
    repeat (40) tick();
    base = 21'h1FFFFC;
    wait_fs(FT);

    // Frame 3: wrapping addresses, Enable dropped mid-frame.
    rd_cnt = 0;
    repeat (50) tick();
    en = 1'b0;
    repeat (FT - 1 - 50) tick();
    chk("rd_last_frame", 32'(rd_cnt), 32'd32);
    repeat (20) tick();
    chk_idle("drained");
    chk("addr_wrapped", 32'(rd_addr), 32'h00001C);

    // Enable only at the last cycle of frame keeps running.
    base = 21'h002000; en = 1'b1;
    wait_fs(10);
    repeat (10) tick();
    en = 1'b0;
    repeat (FT - 1 - 10) tick();
    en = 1'b1;
    wait_fs(1);

    // Enable dropped exactly at the last cycle: drain, then restart.
    repeat (FT - 1) tick();
    en = 1'b0; c0 = cyc;
    repeat (2) tick();
    en = 1'b1;
    wait_fs(10);
    chk("restart_after_drain", 32'(cyc - c0), 32'(LAT + 3));

    // Reset mid-line with Enable held.
    repeat (33) tick();
    rst = 1'b1;
    tick();
    chk_idle("mid_reset");
    chk("mid_reset_rd_addr", 32'(rd_addr), 32'd0);
    rst = 1'b0; c0 = cyc;
    wait_fs(5);
    chk("fs_after_reset", 32'(cyc - c0), 32'd1);
    repeat (FT) tick();

`ifdef DDT_TX_TEST_PATTERN_EN
    psel = 1'b1;
    wait_fs(FT + 2);
    rd_cnt = 0;
    repeat (FT - 1) tick();
    chk("pattern_no_rd", 32'(rd_cnt), 32'd0);
    psel = 1'b0;
    repeat (5) tick();
`endif

    en = 1'b0;
    repeat (FT + 10) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
